instr_fetch_unit: RTL and testbench

Instruction fetch stage feeding the datapath's instruction decode. Generates the sequential fetch PC, issues single-outstanding read requests to a variable-latency instruction memory, and buffers returned 16-bit instructions with their PCs in a small prefetch queue. Presents them to the datapath over a valid/ready handshake. Accepts a redirect (jump or taken beq/bne target) that flushes the queue and discards any in-flight memory response.

---
 rtl/instr_fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, single-outstanding reads to a
// variable-latency instruction memory, and a small prefetch queue with registered head outputs.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] instr_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FULL,
        ST_KILL
    } state_t;

    state_t           state, state_next;
    logic [15:0]      fetch_pc, fetch_pc_next;
    logic [15:0]      req_pc;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
    logic [CNT_W-1:0] count, count_next;
    logic [15:0]      data_mem [DEPTH];
    logic [15:0]      pc_mem   [DEPTH];
    logic [15:0]      head_instr_next, head_pc_next;
    logic             push, pop;

    assign pop      = instr_valid & instr_ready;
    assign push     = (state == ST_WAIT) & mem_rvalid & ~redirect;
    assign mem_req  = (state == ST_REQ);
    assign mem_addr = fetch_pc;

    // NOTE: combinational blocks use blocking assignments and give every output a
    // default first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        unique case (state)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                if (mem_ack) begin
                    state_next    = ST_WAIT;
                    fetch_pc_next = fetch_pc + 16'd2;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_next = (count_next < FULL_COUNT) ? ST_REQ : ST_FULL;
                end
            end
            ST_FULL: begin
                if (count < FULL_COUNT) begin
                    state_next = ST_REQ;
                end
            end
            ST_KILL: begin
                if (mem_rvalid) begin
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Redirect overrides everything; an acked-but-unreturned response must be drained in KILL.
        if (redirect) begin
            fetch_pc_next = redirect_pc & 16'hFFFE;
            case (state)
                ST_WAIT: state_next = mem_rvalid ? ST_REQ : ST_KILL;
                ST_REQ:  state_next = mem_ack ? ST_KILL : ST_REQ;
                ST_KILL: state_next = mem_rvalid ? ST_REQ : ST_KILL;
                default: state_next = ST_REQ;
            endcase
        end
    end

    always_comb begin
        rd_ptr_next = rd_ptr;
        wr_ptr_next = wr_ptr;
        count_next  = count;
        if (redirect) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_next = count + 1'b1;
                2'b01:   count_next = count - 1'b1;
                default: count_next = count;
            endcase
        end
    end

    // The head registers look one cycle ahead; a push into the slot that becomes
    // the head must be forwarded because storage is written on the same edge.
    always_comb begin
        head_instr_next = data_mem[rd_ptr_next];
        head_pc_next    = pc_mem[rd_ptr_next];
        if (push && (wr_ptr == rd_ptr_next)) begin
            head_instr_next = mem_rdata;
            head_pc_next    = req_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            instr_valid <= 1'b0;
            instr       <= 16'h0000;
            instr_pc    <= 16'h0000;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            if ((state == ST_REQ) && mem_ack) begin
                req_pc <= fetch_pc;
            end
            rd_ptr      <= rd_ptr_next;
            wr_ptr      <= wr_ptr_next;
            count       <= count_next;
            instr_valid <= (count_next != '0);
            if (count_next != '0) begin
                instr    <= head_instr_next;
                instr_pc <= head_pc_next;
            end
        end
    end

    // NOTE: queue storage has no reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a latency-configurable memory model,
// a PC/data scoreboard filled at each ack, and directed fetch/redirect/reset steps.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;

    int          total = 0;
    int          bad = 0;
    int          ack_delay = 0;
    int          lat = 1;
    int          ack_cnt = 0;
    exp_t        sb[$];
    logic [15:0] pop_log[$];
    logic [15:0] exp_pc;

    bit          pending;
    int          rem;
    int          req_wait;
    logic [15:0] pend_addr;
    exp_t        head;

    instr_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while (pop_log.size() < n && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check(tag, pop_log.size() >= n, 1);
    endtask

    task automatic wait_ack(input int budget, input string tag);
        int i;
        i = 0;
        do begin
            @(negedge clk); #1;
            i++;
        end while (!mem_ack && i < budget);
        check(tag, mem_ack, 1);
    endtask

    // Memory model drives at the falling edge; scoreboard samples the settled cycle 2ns later.
    initial begin
        pending    = 1'b0;
        rem        = 0;
        req_wait   = 0;
        pend_addr  = 16'h0000;
        exp_pc     = RESET_PC;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
        forever begin
            @(negedge clk);
            mem_ack    = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                pending  = 1'b0;
                req_wait = 0;
            end else begin
                if (pending) begin
                    rem--;
                    if (rem == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem_word(pend_addr);
                        pending    = 1'b0;
                    end
                end
                if (mem_req) begin
                    if (req_wait >= ack_delay) begin
                        mem_ack   = 1'b1;
                        pending   = 1'b1;
                        pend_addr = mem_addr;
                        rem       = lat;
                        req_wait  = 0;
                    end else begin
                        req_wait++;
                    end
                end else begin
                    req_wait = 0;
                end
            end
            #2;
            if (!rst_n) begin
                sb.delete();
                pop_log.delete();
                ack_cnt = 0;
                exp_pc  = RESET_PC;
            end else begin
                if (instr_valid && instr_ready) begin
                    check("sb_nonempty_at_pop", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        head = sb.pop_front();
                        check("pop_pc", instr_pc, head.pc);
                        check("pop_instr", instr, head.data);
                    end
                    pop_log.push_back(instr_pc);
                end
                if (mem_ack) begin
                    check("req_addr", mem_addr, exp_pc);
                    sb.push_back('{pc: exp_pc, data: mem_word(exp_pc)});
                    exp_pc = exp_pc + 16'd2;
                    ack_cnt++;
                end
                if (redirect) begin
                    sb.delete();
                    pop_log.delete();
                    exp_pc = redirect_pc & 16'hFFFE;
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;

        // Reset values and first-request timing
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", instr_valid, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, RESET_PC);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_low_cycle1", mem_req, 0);
        @(posedge clk); #1;
        check("req_high_cycle2", mem_req, 1);
        @(posedge clk); #1;
        check("valid_low_rvalid_cycle", instr_valid, 0);
        @(posedge clk); #1;
        check("valid_after_rvalid", instr_valid, 1);
        check("first_instr_pc", instr_pc, RESET_PC);
        check("first_instr", instr, mem_word(RESET_PC));
        wait_pops(4, 100, "t1_pops_timeout");
        for (int k = 0; k < 4; k++) check("t1_pc_seq", pop_log[k], RESET_PC + 16'(2 * k));

        // Queue fills to DEPTH with no consumer, then drains in order
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("full_ack_count", ack_cnt, DEPTH);
        check("full_req_low", mem_req, 0);
        check("full_valid", instr_valid, 1);
        check("full_head_pc", instr_pc, 16'h0000);
        @(posedge clk); #1;
        check("stall_head_pc_stable", instr_pc, 16'h0000);
        check("stall_head_instr_stable", instr, mem_word(16'h0000));
        instr_ready = 1'b1;
        wait_pops(5, 200, "t2_pops_timeout");
        for (int k = 0; k < 5; k++) check("t2_pc_seq", pop_log[k], 16'(2 * k));

        // Redirect while a slow response is outstanding
        lat = 3;
        wait_ack(200, "t3_ack_timeout");
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        @(posedge clk); #1;
        redirect = 1'b0;
        check("t3_valid_flushed", instr_valid, 0);
        check("t3_new_addr", mem_addr, 16'h0040);
        check("t3_no_req_while_owed", mem_req, 0);
        wait_pops(1, 200, "t3_pops_timeout");
        check("t3_first_pc", pop_log[0], 16'h0040);

        // Redirect in the same cycle as the response
        lat = 2;
        wait_ack(200, "t4a_ack_timeout");
        @(posedge clk); #1;
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        @(posedge clk); #1;
        redirect = 1'b0;
        check("t4a_valid_flushed", instr_valid, 0);
        check("t4a_new_addr", mem_addr, 16'h0100);
        check("t4a_req_again", mem_req, 1);
        wait_pops(1, 200, "t4a_pops_timeout");
        check("t4a_first_pc", pop_log[0], 16'h0100);

        // Redirect in the same cycle as the ack
        ack_delay = 2;
        lat       = 1;
        wait_ack(200, "t4b_ack_timeout");
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        @(posedge clk); #1;
        redirect = 1'b0;
        check("t4b_valid_flushed", instr_valid, 0);
        check("t4b_new_addr", mem_addr, 16'h0200);
        check("t4b_no_req_while_owed", mem_req, 0);
        wait_pops(2, 200, "t4b_pops_timeout");
        check("t4b_pc0", pop_log[0], 16'h0200);
        check("t4b_pc1", pop_log[1], 16'h0202);
        ack_delay = 0;

        // Odd redirect target and PC wrap
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFD;
        @(posedge clk); #1;
        redirect = 1'b0;
        check("t5_valid_flushed", instr_valid, 0);
        wait_pops(3, 200, "t5_pops_timeout");
        check("t5_pc0", pop_log[0], 16'hFFFC);
        check("t5_pc1", pop_log[1], 16'hFFFE);
        check("t5_pc2", pop_log[2], 16'h0000);

        // Asynchronous reset mid-WAIT with three buffered entries
        rst_n = 1'b0;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        lat         = 3;
        rst_n       = 1'b1;
        for (int i = 0; i < 100 && ack_cnt < 4; i++) begin
            @(posedge clk); #1;
        end
        check("t6_four_acks", ack_cnt, 4);
        check("t6_valid_before_reset", instr_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", instr_valid, 0);
        check("t6_async_req", mem_req, 0);
        check("t6_async_addr", mem_addr, RESET_PC);
        check("t6_async_instr_pc", instr_pc, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_req_after_release", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_req_drop", mem_req, 0);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        rst_n       = 1'b1;
        wait_pops(2, 200, "t6_pops_timeout");
        check("t6_pc0", pop_log[0], RESET_PC);
        check("t6_pc1", pop_log[1], RESET_PC + 16'd2);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
